alu3_seq_core: RTL and testbench

//  Sequential 3-bit ALU core with operand/opcode registers and a small FSM.

---
 rtl/alu3_seq_core.sv | 155 +++++++++++++++
 tb/tb_alu3_seq_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu3_seq_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu3_seq_core
//  Brief    : Sequential 3-bit ALU core (ADD/SUB/AND in one execute cycle,
//             MUL as a 3-step shift-add) feeding a two-digit 7-seg decoder.
//             The 4-bit result is registered and held between operations.
//  Revision : 1.0 - initial release
// ============================================================================
module alu3_seq_core #(
  parameter int unsigned W      = 3,
  parameter int unsigned MSTEPS = W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] data_i,
  input  logic [1:0]   op_i,
  input  logic         load_a_i,
  input  logic         load_b_i,
  input  logic         go_i,
  output logic [W:0]   result_o,
  output logic         neg_o,
  output logic         ovf_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int unsigned CW = (MSTEPS > 1) ? $clog2(MSTEPS) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_MUL  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_MUL = 2'b10;
  localparam logic [1:0] c_OP_AND = 2'b11;

  localparam logic [CW-1:0] c_CNT_LAST = CW'(MSTEPS - 1);

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [1:0]     op_q, op_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     result_q, result_d;
  logic           neg_q, neg_d;
  logic           ovf_q, ovf_d;

  // One shift-add step: partial product B<<cnt gated by multiplier bit A[cnt].
  // The accumulator is 2W bits wide, so the largest product never wraps.
  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_acc_sum;
  assign w_addend  = a_q[cnt_q] ? ({{W{1'b0}}, b_q} << cnt_q) : '0;
  assign w_acc_sum = acc_q + w_addend;

  // Next-state and datapath update for the IDLE/CALC/MUL/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    case (state_q)
      c_IDLE: begin
        if (load_a_i) a_d = data_i;
        if (load_b_i) b_d = data_i;
        // A Go that coincides with any load is dropped; the load still lands.
        if (go_i && !load_a_i && !load_b_i) begin
          op_d = op_i;
          if (op_i == c_OP_MUL) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = c_MUL;
          end else begin
            state_d = c_CALC;
          end
        end
      end
      c_CALC: begin
        neg_d = 1'b0;
        ovf_d = 1'b0;
        case (op_q)
          c_OP_ADD: result_d = {1'b0, a_q} + {1'b0, b_q};
          c_OP_SUB: begin
            // Magnitude in Result, sign reported separately on Neg.
            if (a_q >= b_q) begin
              result_d = {1'b0, a_q - b_q};
            end else begin
              result_d = {1'b0, b_q - a_q};
              neg_d    = 1'b1;
            end
          end
          c_OP_AND: result_d = {1'b0, a_q & b_q};
          default:  result_d = result_q;
        endcase
        state_d = c_DONE;
      end
      c_MUL: begin
        acc_d = w_acc_sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == c_CNT_LAST) begin
          result_d = w_acc_sum[W:0];
          ovf_d    = |w_acc_sum[2*W-1:W+1];
          neg_d    = 1'b0;
          state_d  = c_DONE;
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides everything, aborting any op.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= c_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result_o = result_q;
  assign neg_o    = neg_q;
  assign ovf_o    = ovf_q;
  assign busy_o   = (state_q != c_IDLE);
  assign done_o   = (state_q == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu3_seq_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu3_seq_core
//  Brief    : Self-checking bench for alu3_seq_core against an arithmetic
//             reference model (sum, |difference|, product, bitwise AND).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu3_seq_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] data;
  logic [1:0] op;
  logic       load_a, load_b, go;
  logic [3:0] result;
  logic       neg, ovf, busy, done;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_a = 0, m_b = 0, m_res = 0, m_neg = 0, m_ovf = 0;

  always #5 clk = ~clk;

  alu3_seq_core dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .data_i   (data),
    .op_i     (op),
    .load_a_i (load_a),
    .load_b_i (load_b),
    .go_i     (go),
    .result_o (result),
    .neg_o    (neg),
    .ovf_o    (ovf),
    .busy_o   (busy),
    .done_o   (done)
  );

  // Expected outcome of one operation from plain arithmetic
  function automatic void ref_calc(input int a, input int b, input int opc,
                                   output int r, output int n, output int o);
    r = 0; n = 0; o = 0;
    case (opc)
      0: r = a + b;
      1: if (a < b) begin r = b - a; n = 1; end else r = a - b;
      2: begin r = (a * b) % 16; o = (a * b > 15) ? 1 : 0; end
      default: r = a & b;
    endcase
  endfunction

  // Stimulus: load one or both registers with the same value
  task automatic do_load(input bit la, input bit lb, input int v);
    @(negedge clk);
    data = v[2:0]; load_a = la; load_b = lb;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0;
    if (la) m_a = v;
    if (lb) m_b = v;
  endtask

  // Stimulus: pulse Go and observe the following 8 cycles (sample index 0 is
  // the cycle right after the Go edge). Op is scrambled after Go.
  task automatic run_op(input int opc, output int first_done, output int n_busy,
                        output int n_done, output logic [3:0] res_pre,
                        output logic [3:0] res_d, output logic neg_d,
                        output logic ovf_d);
    @(negedge clk);
    op = opc[1:0]; go = 1'b1;
    @(negedge clk);
    go = 1'b0; op = 2'($urandom);
    res_pre = result; first_done = -1; n_busy = 0; n_done = 0;
    res_d = 'x; neg_d = 1'bx; ovf_d = 1'bx;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = i; res_d = result; neg_d = neg; ovf_d = ovf;
        end
      end
    end
  endtask

  task automatic test_reset();
    int fd, nb, nd; logic [3:0] rp, rd; logic nn, oo;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data = 3'($urandom); op = 2'($urandom);
      go = 1'($urandom); load_a = 1'($urandom); load_b = 1'($urandom);
    end
    @(negedge clk);
    go = 1'b0; load_a = 1'b0; load_b = 1'b0;
    total++;
    if ({result, neg, ovf, busy, done} !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: got res=%0d neg=%0b ovf=%0b busy=%0b done=%0b want all 0",
               result, neg, ovf, busy, done);
    end
    rst = 1'b0;
    m_a = 0; m_b = 0; m_res = 0; m_neg = 0; m_ovf = 0;
    // Only B is loaded: the sum exposes the reset value of A
    do_load(1'b0, 1'b1, 3);
    run_op(0, fd, nb, nd, rp, rd, nn, oo);
    total++;
    if (rd !== 4'd3) begin
      bad++;
      $display("FAIL reset_a_zero: got %0d want 3", rd);
    end
    m_res = 3;
  endtask

  task automatic test_directed();
    int ta[7] = '{7, 2, 5, 3, 7, 6, 5};
    int tb[7] = '{7, 5, 2, 5, 7, 3, 6};
    int to[7] = '{0, 1, 1, 2, 2, 3, 3};
    int r, n, o, fd, nb, nd; logic [3:0] rp, rd; logic nn, oo;
    for (int k = 0; k < 7; k++) begin
      do_load(1'b1, 1'b0, ta[k]);
      do_load(1'b0, 1'b1, tb[k]);
      ref_calc(m_a, m_b, to[k], r, n, o);
      run_op(to[k], fd, nb, nd, rp, rd, nn, oo);
      total++;
      if (rd !== 4'(r) || nn !== 1'(n) || oo !== 1'(o)) begin
        bad++;
        $display("FAIL dir_result[%0d]: got res=%0d neg=%0b ovf=%0b want res=%0d neg=%0d ovf=%0d",
                 k, rd, nn, oo, r, n, o);
      end
      total++;
      if (fd !== ((to[k] == 2) ? 3 : 1) || nd !== 1 || nb !== fd + 1) begin
        bad++;
        $display("FAIL dir_timing[%0d]: got done_at=%0d ndone=%0d busy=%0d want done_at=%0d ndone=1 busy=%0d",
                 k, fd, nd, nb, (to[k] == 2) ? 3 : 1, (to[k] == 2) ? 4 : 2);
      end
      total++;
      if (rp !== 4'(m_res)) begin
        bad++;
        $display("FAIL dir_hold[%0d]: got %0d want %0d", k, rp, m_res);
      end
      m_res = r; m_neg = n; m_ovf = o;
    end
  endtask

  task automatic test_busy_ignore();
    int ndone; logic [3:0] rd; logic od;
    int r, n, o, fd, nb, nd; logic [3:0] rp; logic nn, oo;
    do_load(1'b1, 1'b0, 6);
    do_load(1'b0, 1'b1, 3);
    @(negedge clk);
    op = 2'b10; go = 1'b1;
    @(negedge clk);
    // Inside MUL: these must all be ignored
    op = 2'b00; go = 1'b1; load_a = 1'b1; load_b = 1'b1; data = 3'd1;
    @(negedge clk);
    go = 1'b0; load_a = 1'b0; load_b = 1'b0;
    ndone = 0; rd = 'x; od = 1'bx;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin ndone++; rd = result; od = ovf; end
    end
    ref_calc(m_a, m_b, 2, r, n, o);
    total++;
    if (ndone !== 1 || rd !== 4'(r) || od !== 1'(o)) begin
      bad++;
      $display("FAIL busy_ignore: got ndone=%0d res=%0d ovf=%0b want ndone=1 res=%0d ovf=%0d",
               ndone, rd, od, r, o);
    end
    ref_calc(m_a, m_b, 0, r, n, o);
    run_op(0, fd, nb, nd, rp, rd, nn, oo);
    total++;
    if (rd !== 4'(r)) begin
      bad++;
      $display("FAIL busy_ab_frozen: got %0d want %0d", rd, r);
    end
    m_res = r; m_neg = 0; m_ovf = 0;
  endtask

  task automatic test_go_with_load();
    int nbusy, r, n, o, fd, nb, nd; logic [3:0] rp, rd; logic nn, oo, stable;
    @(negedge clk);
    go = 1'b1; op = 2'b00; load_b = 1'b1; data = 3'd4;
    @(negedge clk);
    go = 1'b0; load_b = 1'b0;
    m_b = 4;
    nbusy = 0; stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (busy || done) nbusy++;
      if (result !== 4'(m_res)) stable = 1'b0;
    end
    total++;
    if (nbusy !== 0 || stable !== 1'b1) begin
      bad++;
      $display("FAIL go_with_load: got busy_cycles=%0d result_stable=%0b want 0 and 1",
               nbusy, stable);
    end
    ref_calc(m_a, m_b, 0, r, n, o);
    run_op(0, fd, nb, nd, rp, rd, nn, oo);
    total++;
    if (rd !== 4'(r)) begin
      bad++;
      $display("FAIL go_load_b_taken: got %0d want %0d", rd, r);
    end
    m_res = r; m_neg = 0; m_ovf = 0;
  endtask

  task automatic test_reset_abort();
    int ndone, r, n, o, fd, nb, nd; logic [3:0] rp, rd; logic nn, oo;
    do_load(1'b1, 1'b0, 5);
    do_load(1'b0, 1'b1, 6);
    @(negedge clk);
    op = 2'b10; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({result, neg, ovf, busy, done} !== 8'h00) begin
      bad++;
      $display("FAIL reset_abort: got res=%0d neg=%0b ovf=%0b busy=%0b done=%0b want all 0",
               result, neg, ovf, busy, done);
    end
    rst = 1'b0;
    m_a = 0; m_b = 0; m_res = 0; m_neg = 0; m_ovf = 0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d active cycles want 0", ndone);
    end
    // Only A is loaded: the difference exposes the reset value of B
    do_load(1'b1, 1'b0, 5);
    ref_calc(m_a, m_b, 1, r, n, o);
    run_op(1, fd, nb, nd, rp, rd, nn, oo);
    total++;
    if (rd !== 4'(r) || nn !== 1'(n)) begin
      bad++;
      $display("FAIL abort_b_zero: got res=%0d neg=%0b want res=%0d neg=%0d", rd, nn, r, n);
    end
    m_res = r; m_neg = n; m_ovf = o;
  endtask

  task automatic test_random();
    int v, opc, r, n, o, fd, nb, nd, efd; logic [3:0] rp, rd; logic nn, oo;
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0: do_load(1'b1, 1'b0, $urandom_range(0, 7));
        1: do_load(1'b0, 1'b1, $urandom_range(0, 7));
        2: begin
             v = $urandom_range(0, 7);
             do_load(1'b1, 1'b1, v);
           end
        default: begin
             do_load(1'b1, 1'b0, $urandom_range(0, 7));
             do_load(1'b0, 1'b1, $urandom_range(0, 7));
           end
      endcase
      opc = $urandom_range(0, 3);
      ref_calc(m_a, m_b, opc, r, n, o);
      efd = (opc == 2) ? 3 : 1;
      run_op(opc, fd, nb, nd, rp, rd, nn, oo);
      total++;
      if (rd !== 4'(r) || nn !== 1'(n) || oo !== 1'(o) || fd !== efd || nd !== 1 ||
          nb !== efd + 1 || rp !== 4'(m_res)) begin
        bad++;
        $display("FAIL rand[%0d] a=%0d b=%0d op=%0d: got res=%0d neg=%0b ovf=%0b done_at=%0d ndone=%0d busy=%0d pre=%0d want res=%0d neg=%0d ovf=%0d done_at=%0d ndone=1 busy=%0d pre=%0d",
                 k, m_a, m_b, opc, rd, nn, oo, fd, nd, nb, rp, r, n, o, efd, efd + 1, m_res);
      end
      m_res = r; m_neg = n; m_ovf = o;
    end
  endtask

  initial begin
    rst = 1'b1; data = '0; op = '0; load_a = 1'b0; load_b = 1'b0; go = 1'b0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_go_with_load();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
